regfile_mp: RTL

- Parametrised multi-port register file; next-generation replacement for the fixed 32x32, 2-read/1-write register file in the datapath.
- Generalises data width, depth, read-port count and write-port count.
- Adds: same-cycle write-to-read bypass, deterministic write-collision priority, optional hardwired-zero register 0, optional registered read outputs.
- Feeds the ALU operand path; written back from the writeback stage.

---
 rtl/regfile_mp.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write collision priority,
// optional same-cycle bypass, hardwired-zero register 0 and registered reads.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NWR-1:0]           RegWrite,
  input  logic [NWR*ADDR_W-1:0]    WriteRegNo,
  input  logic [NWR*DATA_W-1:0]    WriteData,
  input  logic [NRD*ADDR_W-1:0]    ReadReg,
  output logic [NRD*DATA_W-1:0]    ReadData
);

  localparam int NSLOT = 1 << ADDR_W;

  // Whole address space is modelled; slots with no storage read as zero.
  logic [DATA_W-1:0]     slot_data [NSLOT];
  logic [NSLOT-1:0]      slot_live;
  logic [NRD*DATA_W-1:0] read_next;

  genvar gi;

  for (gi = 0; gi < NSLOT; gi++) begin : g_slot
    localparam bit LIVE = (gi < DEPTH) && !((ZERO_REG != 0) && (gi == 0));

    assign slot_live[gi] = LIVE;

    if (LIVE) begin : g_live
      logic              wr_hit;
      logic [DATA_W-1:0] data_reg;
      logic [DATA_W-1:0] data_next;

      // Later ports overwrite earlier matches, so the highest index wins.
      always_comb begin
        wr_hit    = 1'b0;
        data_next = data_reg;
        for (int k = 0; k < NWR; k++) begin
          if (RegWrite[k] && (WriteRegNo[k*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
            wr_hit    = 1'b1;
            data_next = WriteData[k*DATA_W +: DATA_W];
          end
        end
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          data_reg <= '0;
        end else if (wr_hit) begin
          data_reg <= data_next;
        end
      end

      assign slot_data[gi] = data_reg;
    end else begin : g_dead
      assign slot_data[gi] = '0;
    end
  end

  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ReadReg[gi*ADDR_W +: ADDR_W];

    // Bypass only forwards writes that would actually commit this edge.
    always_comb begin
      data = slot_data[addr];
      if ((BYPASS != 0) && !Reset && slot_live[addr]) begin
        for (int k = 0; k < NWR; k++) begin
          if (RegWrite[k] && (WriteRegNo[k*ADDR_W +: ADDR_W] == addr)) begin
            data = WriteData[k*DATA_W +: DATA_W];
          end
        end
      end
    end

    assign read_next[gi*DATA_W +: DATA_W] = data;
  end

  if (READ_LAT != 0) begin : g_lat
    logic [NRD*DATA_W-1:0] read_reg;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        read_reg <= '0;
      end else begin
        read_reg <= read_next;
      end
    end

    assign ReadData = read_reg;
  end else begin : g_comb
    assign ReadData = read_next;
  end

endmodule
